// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals shared by mem_port_arbiter.
// master: the arbiter's view; slave: the requesters plus memory that surround it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_func;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_err;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_valid, if_stall,
        input  dm_req, dm_we, dm_func, dm_addr, dm_wdata,
        output dm_rdata, dm_valid, dm_err, dm_stall,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_valid, if_stall,
        output dm_req, dm_we, dm_func, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid, dm_err, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction at a time.
// Optional watchdog on stuck memory handshakes: define MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

    state_t              state_q, state_d;
    logic                owner_dm_q;
    logic                we_q;
    logic                err_q;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [STREAK_W-1:0] streak_q;

    logic                grant_dm;
    logic                grant_if;
    logic                starve;
    logic                dm_misaligned;
    logic                timeout;
    logic [3:0]          dm_be;
    logic [DATA_W-1:0]   dm_lane_wdata;

    // Low fetch-address bits and the sign bit of funcMem play no part here.
    logic unused_bits;
    assign unused_bits = ^{bus.if_addr[1:0], bus.dm_func[2]};

    assign starve = (streak_q == STREAK_W'(STARVE_MAX));

    always_comb begin
        dm_be         = 4'b1111;
        dm_lane_wdata = bus.dm_wdata;
        dm_misaligned = 1'b0;
        case (bus.dm_func[1:0])
            2'b00: begin
                dm_be         = 4'b0001 << bus.dm_addr[1:0];
                dm_lane_wdata = DATA_W'(bus.dm_wdata[7:0]) << {bus.dm_addr[1:0], 3'b000};
            end
            2'b01: begin
                dm_be         = 4'b0011 << {bus.dm_addr[1], 1'b0};
                dm_lane_wdata = DATA_W'(bus.dm_wdata[15:0]) << {bus.dm_addr[1], 4'b0000};
                dm_misaligned = bus.dm_addr[0];
            end
            default: begin
                dm_misaligned = (bus.dm_addr[1:0] != 2'b00);
            end
        endcase
    end

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            stuck;

    assign stuck   = (state_q == REQ && !bus.mem_gnt) || (state_q == WAIT && !bus.mem_rvalid);
    assign timeout = stuck && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (stuck) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT > 0);
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_dm     = 1'b0;
        grant_if     = 1'b0;
        bus.mem_req  = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_rdata = '0;
        bus.dm_valid = 1'b0;
        bus.dm_err   = 1'b0;
        bus.dm_rdata = '0;
        case (state_q)
            IDLE: begin
                // DM wins ties unless IF has been passed over STARVE_MAX times in a row.
                if (bus.dm_req && !(starve && bus.if_req)) begin
                    grant_dm = 1'b1;
                    state_d  = dm_misaligned ? RESP : REQ;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (owner_dm_q) begin
                    bus.dm_valid = 1'b1;
                    bus.dm_err   = err_q;
                    bus.dm_rdata = rdata_q;
                end else begin
                    bus.if_valid = 1'b1;
                    bus.if_rdata = rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.if_stall  = bus.if_req & ~bus.if_valid;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_valid;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            streak_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.if_req || grant_if) begin
                        streak_q <= '0;
                    end else if (grant_dm && !starve) begin
                        streak_q <= streak_q + 1'b1;
                    end
                    // A misaligned access never reaches memory, so its strobes stay quiet.
                    if (grant_dm) begin
                        owner_dm_q <= 1'b1;
                        we_q       <= bus.dm_we & ~dm_misaligned;
                        err_q      <= dm_misaligned;
                        be_q       <= (bus.dm_we && !dm_misaligned) ? dm_be : 4'b0000;
                        addr_q     <= {bus.dm_addr[ADDR_W-1:2], 2'b00};
                        wdata_q    <= (bus.dm_we && !dm_misaligned) ? dm_lane_wdata : '0;
                        rdata_q    <= '0;
                    end else if (grant_if) begin
                        owner_dm_q <= 1'b0;
                        we_q       <= 1'b0;
                        err_q      <= 1'b0;
                        be_q       <= 4'b0000;
                        addr_q     <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        wdata_q    <= '0;
                        rdata_q    <= '0;
                    end
                end
                REQ: begin
                    if (!bus.mem_gnt && timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= owner_dm_q ? '0 : NOP_INSN;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rdata_q <= we_q ? '0 : bus.mem_rdata;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= owner_dm_q ? '0 : NOP_INSN;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-stepped memory model plus a completion scoreboard.
// Build with MEM_ARB_WATCHDOG_EN to also exercise the timeout path.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int mem_req_cnt = 0;
    int if_done = 0;
    int dm_done = 0;
    int dm_done_at_if = 0;
    int base;

    logic [31:0] if_exp[$];
    logic [31:0] dm_exp_data[$];
    logic        dm_exp_err[$];
    logic [31:0] dm_todo[$];

    logic        pend = 1'b0;
    logic        gnt_on = 1'b1;
    logic        rv_on = 1'b1;
    logic [31:0] pend_data = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        last_we = 1'b0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_if(input logic [31:0] a, input logic [31:0] exp);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if_exp.push_back(exp);
    endtask

    task automatic start_dm(input logic we, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input logic wd_to);
        logic mis;
        mis = (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_func  = f;
        bus.dm_addr  = a;
        bus.dm_wdata = wd;
        dm_exp_err.push_back(mis || wd_to);
        dm_exp_data.push_back((mis || we || wd_to) ? 32'h0 : mem_val({a[31:2], 2'b00}));
    endtask

    // One clock: sample at the falling edge, score completions, then let the memory model react.
    task automatic step();
        @(negedge clk);
        check("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~bus.if_valid));
        check("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req & ~bus.dm_valid));
        if (bus.mem_req) mem_req_cnt++;
        if (bus.if_valid) begin
            if (if_exp.size() == 0) check("if_spurious", 32'(bus.if_valid), 32'd0);
            else check("if_rdata", bus.if_rdata, if_exp.pop_front());
            if_done++;
            dm_done_at_if = dm_done;
            bus.if_req = 1'b0;
        end
        if (bus.dm_valid) begin
            if (dm_exp_data.size() == 0) begin
                check("dm_spurious", 32'(bus.dm_valid), 32'd0);
            end else begin
                check("dm_rdata", bus.dm_rdata, dm_exp_data.pop_front());
                check("dm_err", 32'(bus.dm_err), 32'(dm_exp_err.pop_front()));
            end
            dm_done++;
            if (dm_todo.size() != 0) start_dm(1'b0, 3'b010, dm_todo.pop_front(), 32'h0, 1'b0);
            else bus.dm_req = 1'b0;
        end
        bus.mem_rvalid = pend && rv_on;
        bus.mem_rdata  = bus.mem_rvalid ? pend_data : 32'h0;
        if (bus.mem_rvalid) pend = 1'b0;
        bus.mem_gnt = bus.mem_req && gnt_on;
        if (bus.mem_gnt) begin
            pend       = 1'b1;
            pend_data  = bus.mem_we ? 32'h0 : mem_val(bus.mem_addr);
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_be    = bus.mem_be;
            last_we    = bus.mem_we;
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((if_exp.size() != 0 || dm_exp_data.size() != 0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            check("drain_timeout", 32'(if_exp.size() + dm_exp_data.size()), 32'd0);
            if_exp.delete();
            dm_exp_data.delete();
            dm_exp_err.delete();
            dm_todo.delete();
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
        end
        step();
        step();
    endtask

    initial begin
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_func    = 3'b000;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        $display("[TB] start");

        step();
        step();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
        check("rst_dm_err", 32'(bus.dm_err), 32'd0);
        rst_n = 1'b1;
        step();

        // IF alone: valid exactly three cycles after the request cycle.
        base = if_done;
        start_if(32'h0000_0100, 32'hDEAD_BEEF);
        step();
        step();
        check("if_lat_early", 32'(if_done), 32'(base));
        step();
        check("if_lat", 32'(if_done), 32'(base + 1));
        check("if_be", 32'(last_be), 32'd0);
        check("if_we", 32'(last_we), 32'd0);
        check("if_addr", last_addr, 32'h0000_0100);
        drain(50);
        start_if(32'h0000_010E, mem_val(32'h0000_010C));
        drain(50);
        check("if_addr_low_bits", last_addr, 32'h0000_010C);

        // Collision: DM served first, IF next.
        base = dm_done;
        start_if(32'h0000_0104, mem_val(32'h0000_0104));
        start_dm(1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0);
        drain(50);
        check("coll_dm_first", 32'(dm_done_at_if), 32'(base + 1));

        // Starvation: four DM grants, then IF forced through.
        base = dm_done;
        start_if(32'h0000_0108, mem_val(32'h0000_0108));
        start_dm(1'b0, 3'b010, 32'h0000_0500, 32'h0, 1'b0);
        dm_todo = '{32'h504, 32'h508, 32'h50C, 32'h510, 32'h514};
        drain(200);
        check("starve_dm_before_if", 32'(dm_done_at_if - base), 32'd4);
        check("starve_dm_total", 32'(dm_done - base), 32'd6);

        // Stores: lane placement and byte enables.
        start_dm(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 1'b0);
        drain(50);
        check("sb_be", 32'(last_be), 32'h8);
        check("sb_wdata", last_wdata, 32'hAB00_0000);
        check("sb_we", 32'(last_we), 32'd1);
        check("sb_addr", last_addr, 32'h0000_0200);
        start_dm(1'b1, 3'b001, 32'h0000_0206, 32'h1234_CDEF, 1'b0);
        drain(50);
        check("sh_be", 32'(last_be), 32'hC);
        check("sh_wdata", last_wdata, 32'hCDEF_0000);
        start_dm(1'b1, 3'b000, 32'h0000_0201, 32'hFFFF_FF5A, 1'b0);
        drain(50);
        check("sb1_be", 32'(last_be), 32'h2);
        check("sb1_wdata", last_wdata, 32'h0000_5A00);

        // Loads with the unsigned funcMem encodings.
        start_dm(1'b0, 3'b110, 32'h0000_030C, 32'h0, 1'b0);
        drain(50);
        check("lw_be", 32'(last_be), 32'd0);
        check("lw_we", 32'(last_we), 32'd0);
        start_dm(1'b0, 3'b100, 32'h0000_0311, 32'h0, 1'b0);
        drain(50);
        check("lbu_addr", last_addr, 32'h0000_0310);

        // Misaligned accesses never touch memory.
        base = mem_req_cnt;
        start_dm(1'b1, 3'b010, 32'h0000_0202, 32'h1122_3344, 1'b0);
        drain(50);
        start_dm(1'b0, 3'b101, 32'h0000_0205, 32'h0, 1'b0);
        drain(50);
        check("mis_no_mem_req", 32'(mem_req_cnt), 32'(base));

        // Reset while waiting for read data, then a stray rvalid in IDLE.
        rv_on = 1'b0;
        start_dm(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b0);
        step();
        step();
        rst_n      = 1'b0;
        bus.dm_req = 1'b0;
        dm_exp_data.delete();
        dm_exp_err.delete();
        step();
        rst_n = 1'b1;
        rv_on = 1'b1;
        step();
        step();
        check("rwait_mem_req", 32'(bus.mem_req), 32'd0);
        check("rwait_mem_addr", bus.mem_addr, 32'd0);
        check("rwait_mem_be", 32'(bus.mem_be), 32'd0);
        check("rwait_dm_valid", 32'(bus.dm_valid), 32'd0);
        check("rwait_dm_rdata", bus.dm_rdata, 32'd0);
        step();
        base = dm_done;
        start_dm(1'b0, 3'b010, 32'h0000_0404, 32'h0, 1'b0);
        step();
        step();
        check("post_rst_early", 32'(dm_done), 32'(base));
        step();
        check("post_rst_lat", 32'(dm_done), 32'(base + 1));
        drain(20);

`ifdef MEM_ARB_WATCHDOG_EN
        rv_on = 1'b0;
        start_dm(1'b0, 3'b010, 32'h0000_0600, 32'h0, 1'b1);
        drain(100);
        pend  = 1'b0;
        start_if(32'h0000_0700, 32'h0000_0013);
        drain(100);
        pend  = 1'b0;
        rv_on = 1'b1;
        start_dm(1'b0, 3'b010, 32'h0000_0604, 32'h0, 1'b0);
        drain(50);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
